// File: rtl/mem_arbiter_pkg.sv
// Shared types and policy constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    localparam int PRI_DATA = 0;
    localparam int PRI_RR   = 1;

    function automatic port_t other_port(input port_t p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational grant selection between the fetch port and the data port.
import mem_arbiter_pkg::*;

module arb_grant #(
    parameter int PRIORITY = PRI_DATA
) (
    input  logic  i_req,
    input  logic  d_any,
    input  port_t last_grant,
    input  logic  excl_en,
    input  port_t excl_port,
    output logic  grant_valid,
    output port_t grant_port
);

    logic i_ok;
    logic d_ok;

    always_comb begin
        // The port just served still holds its request during RESP; mask it.
        i_ok        = i_req && !(excl_en && (excl_port == PORT_I));
        d_ok        = d_any && !(excl_en && (excl_port == PORT_D));
        grant_valid = i_ok || d_ok;
        grant_port  = PORT_I;
        if (i_ok && d_ok) begin
            grant_port = (PRIORITY == PRI_RR) ? other_port(last_grant) : PORT_D;
        end else if (d_ok) begin
            grant_port = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto a single fixed-latency RAM port
// and returns one-cycle ready pulses with captured read data.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LATENCY  = 1,
    parameter int PRIORITY = 0,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [BE_W-1:0]   ram_be,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int AL_W  = $clog2(BE_W);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << AL_W;

    state_t            state_q, state_d;
    port_t             grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [BE_W-1:0]   ram_be_q, ram_be_d;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic  d_any;
    logic  grant_valid;
    port_t grant_port;
    logic  start;

    assign d_any = d_ren || d_wen;

    arb_grant #(
        .PRIORITY (PRIORITY)
    ) u_arb_grant (
        .i_req       (i_req),
        .d_any       (d_any),
        .last_grant  (grant_q),
        .excl_en     (state_q == RESP),
        .excl_port   (grant_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        start       = 1'b0;

        case (state_q)
            IDLE: start = grant_valid;
            BUSY: begin
                if (cnt_q == '0) begin
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    state_d   = RESP;
                    if (ram_ren_q) begin
                        if (grant_q == PORT_I) i_rdata_d = ram_rdata;
                        else                   d_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                start   = grant_valid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new grant from IDLE or RESP loads the RAM-side registers directly.
        if (start) begin
            state_d = BUSY;
            grant_d = grant_port;
            cnt_d   = CNT_W'(LATENCY - 1);
            if (grant_port == PORT_D) begin
                ram_addr_d  = d_addr & ADDR_MASK;
                ram_wdata_d = d_wdata;
                ram_wen_d   = d_wen;
                ram_ren_d   = !d_wen;
                ram_be_d    = d_wen ? d_be : {BE_W{1'b1}};
            end else begin
                ram_addr_d = i_addr & ADDR_MASK;
                ram_wen_d  = 1'b0;
                ram_ren_d  = 1'b1;
                ram_be_d   = {BE_W{1'b1}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= PORT_I;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_ready   = (state_q == RESP) && (grant_q == PORT_I);
    assign d_ready   = (state_q == RESP) && (grant_q == PORT_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_be    = ram_be_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: A = LATENCY 2 / data priority, B = LATENCY 2 / round-robin,
// C = LATENCY 1 / data priority, all driven from the same request inputs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_ren = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] ram_rdata = '0;

    logic [31:0] a_i_rdata, a_d_rdata, a_ram_addr, a_ram_wdata;
    logic [31:0] b_i_rdata, b_d_rdata, b_ram_addr, b_ram_wdata;
    logic [31:0] c_i_rdata, c_d_rdata, c_ram_addr, c_ram_wdata;
    logic [3:0]  a_ram_be, b_ram_be, c_ram_be;
    logic        a_i_ready, a_d_ready, a_ram_ren, a_ram_wen;
    logic        b_i_ready, b_d_ready, b_ram_ren, b_ram_wen;
    logic        c_i_ready, c_d_ready, c_ram_ren, c_ram_wen;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .PRIORITY(0)) u_a (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(a_i_rdata), .i_ready(a_i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(a_d_rdata), .d_ready(a_d_ready),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_be(a_ram_be),
        .ram_ren(a_ram_ren), .ram_wen(a_ram_wen), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .PRIORITY(1)) u_b (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(b_i_rdata), .i_ready(b_i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(b_d_rdata), .d_ready(b_d_ready),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_be(b_ram_be),
        .ram_ren(b_ram_ren), .ram_wen(b_ram_wen), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .PRIORITY(0)) u_c (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(c_i_rdata), .i_ready(c_i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(c_d_rdata), .d_ready(c_d_ready),
        .ram_addr(c_ram_addr), .ram_wdata(c_ram_wdata), .ram_be(c_ram_be),
        .ram_ren(c_ram_ren), .ram_wen(c_ram_wen), .ram_rdata(ram_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_ram_ren", a_ram_ren, 0);
        chk("rst_ram_wen", a_ram_wen, 0);
        chk("rst_ram_addr", a_ram_addr, 0);
        chk("rst_ram_be", a_ram_be, 0);
        chk("rst_i_ready", a_i_ready, 0);
        chk("rst_d_ready", a_d_ready, 0);
        chk("rst_i_rdata", a_i_rdata, 0);
        chk("rst_d_rdata", a_d_rdata, 0);

        // Single fetch, LATENCY 2
        i_req = 1'b1;
        i_addr = 32'h0000_0104;
        step();
        chk("f1_ren_c1", a_ram_ren, 1);
        chk("f1_addr", a_ram_addr, 32'h104);
        chk("f1_be", a_ram_be, 4'hF);
        chk("f1_wen", a_ram_wen, 0);
        chk("f1_ready_c1", a_i_ready, 0);
        step();
        chk("f1_ren_c2", a_ram_ren, 1);
        ram_rdata = 32'h00A0_0093;
        step();
        chk("f1_i_ready", a_i_ready, 1);
        chk("f1_i_rdata", a_i_rdata, 32'h00A0_0093);
        chk("f1_ren_resp", a_ram_ren, 0);
        chk("f1_d_ready", a_d_ready, 0);
        i_req = 1'b0;
        step();
        chk("f1_ready_one", a_i_ready, 0);
        chk("f1_rdata_hold", a_i_rdata, 32'h00A0_0093);

        // Data priority: both raised together, fetch chains from RESP
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h40;
        d_ren = 1'b1;
        d_addr = 32'h80;
        ram_rdata = 32'h1111_1111;
        step();
        chk("p0_first_addr", a_ram_addr, 32'h80);
        chk("p0_first_ren", a_ram_ren, 1);
        step();
        step();
        chk("p0_d_ready", a_d_ready, 1);
        chk("p0_d_rdata", a_d_rdata, 32'h1111_1111);
        chk("p0_i_wait", a_i_ready, 0);
        d_ren = 1'b0;
        ram_rdata = 32'h2222_2222;
        step();
        chk("p0_chain_addr", a_ram_addr, 32'h40);
        chk("p0_chain_ren", a_ram_ren, 1);
        chk("p0_d_ready_one", a_d_ready, 0);
        step();
        chk("p0_i_early", a_i_ready, 0);
        step();
        chk("p0_i_ready", a_i_ready, 1);
        chk("p0_i_rdata", a_i_rdata, 32'h2222_2222);
        i_req = 1'b0;
        step();

        // Write with both strobes set; d_rdata keeps the earlier load value
        d_wen = 1'b1;
        d_ren = 1'b1;
        d_addr = 32'h203;
        d_be = 4'b0011;
        d_wdata = 32'hDEAD_BEEF;
        ram_rdata = 32'h5555_5555;
        step();
        chk("wr_wen", a_ram_wen, 1);
        chk("wr_ren", a_ram_ren, 0);
        chk("wr_addr", a_ram_addr, 32'h200);
        chk("wr_be", a_ram_be, 4'b0011);
        chk("wr_wdata", a_ram_wdata, 32'hDEAD_BEEF);
        step();
        step();
        chk("wr_d_ready", a_d_ready, 1);
        chk("wr_d_rdata", a_d_rdata, 32'h1111_1111);
        chk("wr_wen_resp", a_ram_wen, 0);
        d_wen = 1'b0;
        d_ren = 1'b0;
        d_be = 4'b0000;

        // Round-robin with both ports held: D, I, D, I
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h10;
        d_ren = 1'b1;
        d_addr = 32'h20;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("rr_d_ready_%0d", k), b_d_ready, (k == 3 || k == 9));
            chk($sformatf("rr_i_ready_%0d", k), b_i_ready, (k == 6 || k == 12));
        end
        i_req = 1'b0;
        d_ren = 1'b0;

        // Tie right after a data access: priority picks D, round-robin picks I
        reset = 1'b1;
        step();
        reset = 1'b0;
        d_ren = 1'b1;
        d_addr = 32'h20;
        step();
        step();
        step();
        chk("tie_pre_d_ready", b_d_ready, 1);
        d_ren = 1'b0;
        step();
        i_req = 1'b1;
        d_ren = 1'b1;
        step();
        chk("tie_p0_addr", a_ram_addr, 32'h20);
        chk("tie_rr_addr", b_ram_addr, 32'h10);
        i_req = 1'b0;
        d_ren = 1'b0;

        // Reset in the second BUSY cycle aborts the access
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h300;
        step();
        step();
        chk("ab_busy2_ren", a_ram_ren, 1);
        reset = 1'b1;
        step();
        chk("ab_ren", a_ram_ren, 0);
        chk("ab_i_ready", a_i_ready, 0);
        chk("ab_ram_addr", a_ram_addr, 0);
        chk("ab_i_rdata", a_i_rdata, 0);
        reset = 1'b0;
        step();
        chk("ab_fresh_ren", a_ram_ren, 1);
        chk("ab_fresh_ready", a_i_ready, 0);
        ram_rdata = 32'h0000_0077;
        step();
        step();
        chk("ab_fresh_i_ready", a_i_ready, 1);
        chk("ab_fresh_i_rdata", a_i_rdata, 32'h77);
        i_req = 1'b0;

        // LATENCY 1, fetch held high: one access every three cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h8;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("l1_ren_%0d", k), c_ram_ren, (k % 3 == 1));
            chk($sformatf("l1_ready_%0d", k), c_i_ready, (k % 3 == 2));
        end
        i_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the CPU instruction-fetch port and data port. It serialises both onto one RAM interface with a parameterised fixed access latency. It generates the `i_ready`/`d_ready` handshakes the datapath stalls on, and returns captured read data. It replaces the unimplemented request unit, adding configurable widths, latency, byte enables and a selectable arbitration policy.

## Interface
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, data width in bits; must be a multiple of 8, with `BE_W = DATA_W/8`.
- `LATENCY`, 1, RAM cycles per access, minimum 1.
- `PRIORITY`, 0, arbitration policy: 0 = data port always wins, 1 = round-robin.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  instruction fetch request; held until `i_ready`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_rdata`  out  DATA_W  fetched word; valid while `i_ready`=1, held otherwise.
- `i_ready`  out  1  one-cycle completion pulse for the fetch port.
- `d_ren`, `d_wen`  in  1  data read / write request; held until `d_ready`.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_be`  in  BE_W  store byte enables.
- `d_rdata`  out  DATA_W  load data; valid while `d_ready`=1, held otherwise.
- `d_ready`  out  1  one-cycle completion pulse for the data port.
- `ram_addr`  out  ADDR_W  word-aligned RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_be`  out  BE_W  RAM byte enables.
- `ram_ren`, `ram_wen`  out  1  RAM strobes.
- `ram_rdata`  in  DATA_W  RAM read data; valid in the last strobe cycle.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE**
  - If any request is present, grant one port.
  - Load the registered RAM outputs and load the counter with `LATENCY-1`.
  - Next state is BUSY.
- **BUSY**
  - Strobes are held.
  - The counter decrements each cycle.
  - At counter = 0, on a read, capture `ram_rdata` into the granted port's rdata register. Next state is RESP.
- **RESP**
  - Strobes are low.
  - Ready is asserted for the granted port only.
  - The port just served is ignored, because its request is still high this cycle.
  - If the other port requests, grant it, load the RAM outputs and the counter, and go to BUSY. Otherwise go to IDLE.
- **Arbitration**
  - `PRIORITY`=0: when both ports request, the data port wins.
  - `PRIORITY`=1: on a tie, grant the port not in `last_grant`. `last_grant` updates on every grant and resets to I, so the first tie after reset goes to D.
- **Operation type**
  - A fetch is always a read: `ram_be` is all ones.
  - If `d_wen` and `d_ren` are both set, the access is a write. `d_rdata` is not updated.
  - A data read drives `ram_be` all ones. A write drives `ram_be = d_be`.
- **Address**
  - `ram_addr` = request address with the low `$clog2(BE_W)` bits forced to 0.
- **Request dropped mid-BUSY**
  - The access completes and the ready pulse is still issued (protocol violation, but behaviour is defined).
- **Reset**
  - Every output goes to 0 at the next edge. This applies to `ram_*`, both ready pulses and both rdata registers.
  - State returns to IDLE and `last_grant` = I.
  - Reset mid-BUSY aborts the access with no ready pulse.

## Timing
- Request sampled at edge t (in IDLE):
  - strobes are high in cycles t+1 … t+LATENCY;
  - ready is high in cycle t+LATENCY+1;
  - rdata is valid in the same cycle as ready.
- Request-to-ready latency is `LATENCY+1` cycles. Ready lasts exactly one cycle.
- All outputs are registered or decoded from state only. There are no combinational paths from request inputs to outputs.
- When the other port is waiting, RESP→BUSY chaining leaves no idle cycle between accesses.
- A single requester issuing back-to-back requests incurs one idle cycle per access. Its throughput is one access per `LATENCY+2` cycles.
- Counter width is `$clog2(LATENCY+1)`.

## Structure
- `mem_arbiter_pkg` holds:
  - the `state_t` enum (IDLE, BUSY, RESP);
  - the `port_t` enum (PORT_I, PORT_D);
  - the policy constants `PRI_DATA` = 0 and `PRI_RR` = 1.
- Sub-module `arb_grant` is combinational. Its inputs are `i_req`, `d_any`, `last_grant`, `PRIORITY`, and the excluded port (used in RESP). Its outputs are `grant_valid` and `grant_port`.
- The FSM, counter and output registers live in `mem_arbiter`.

## Test plan
- Reset with LATENCY=2; `i_req`=1, `i_addr`=0x0000_0104 → `ram_addr`=0x104 and `ram_ren`=1 for 2 cycles. `ram_rdata`=0x00A0_0093 in the last cycle → `i_ready`=1 and `i_rdata`=0x00A0_0093 three cycles after the sampling edge.
- PRIORITY=0, `i_req` and `d_ren` raised together → data served first. Fetch starts directly from RESP, with `i_ready` three cycles after `d_ready`.
- PRIORITY=1, both ports continuously requesting → grants alternate D, I, D, I. Check the first four ready pulses.
- Write `d_wen`=`d_ren`=1, `d_addr`=0x203, `d_be`=4'b0011, `d_wdata`=0xDEAD_BEEF → `ram_wen`=1, `ram_ren`=0, `ram_addr`=0x200, `ram_be`=0011. `d_rdata` is unchanged.
- `reset` asserted in the second BUSY cycle → all strobes 0 next edge and no ready pulse. A fresh `i_req` completes normally.
- LATENCY=1, single requester holding `i_req` across ready → exactly one `i_ready` per request, with no duplicate access in the RESP cycle.
